// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-beat AXI4 slave in front of a 1-cycle-latency word memory,
// with one exclusive-access reservation and one transaction in flight at a time.
module axi_mem_slave #(
  parameter int MEM_BYTES = 4096,
  parameter int AXI_DW = 32,
  localparam int AW = ($clog2(MEM_BYTES) > 2) ? $clog2(MEM_BYTES) - 2 : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [AXI_DW-1:0] wdata,
  input  logic [AXI_DW/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [AXI_DW-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD_MEM, RD_RESP, WR_MEM, WR_RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, resv_idx_q, resv_idx_d;
  logic lock_q, lock_d, ok_q, ok_d, resv_v_q, resv_v_d;
  logic [3:0] strb_q, strb_d;
  logic [31:0] data_q, data_d;
  logic [1:0] resp_q, resp_d, ar_err, aw_err;
  logic resv_hit;
  logic unused_ok;
  assign unused_ok = ^{awsize, arsize, awcache, arcache, awprot, arprot, wlast, wdata, wstrb, araddr[1:0], awaddr[1:0]};
  always_comb begin
    ar_err = (arlen != 8'd0 || arburst == 2'b00) ? 2'b10 : (araddr >= 32'(MEM_BYTES)) ? 2'b11 : 2'b00;
    aw_err = (awlen != 8'd0 || awburst == 2'b00) ? 2'b10 : (awaddr >= 32'(MEM_BYTES)) ? 2'b11 : 2'b00;
    resv_hit = resv_v_q && resv_idx_q == awaddr[AW+1:2];
    arready = !rst && state_q == IDLE;
    awready = !rst && state_q == IDLE && awvalid && wvalid && !arvalid;
    wready = awready;
    state_d = state_q;
    addr_d = addr_q;
    lock_d = lock_q;
    ok_d = ok_q;
    strb_d = strb_q;
    data_d = data_q;
    resp_d = resp_q;
    resv_v_d = resv_v_q;
    resv_idx_d = resv_idx_q;
    case (state_q)
      IDLE: if (arready && arvalid) begin
        state_d = RD_MEM;
        addr_d = araddr[AW+1:2];
        lock_d = arlock;
        ok_d = ar_err == 2'b00;
        resp_d = (ar_err != 2'b00) ? ar_err : {1'b0, arlock};
      end else if (awready) begin
        state_d = WR_MEM;
        addr_d = awaddr[AW+1:2];
        lock_d = awlock;
        strb_d = wstrb[3:0];
        data_d = wdata[31:0];
        // a failed exclusive write is suppressed but still answers OKAY
        ok_d = aw_err == 2'b00 && (!awlock || resv_hit);
        resp_d = (aw_err != 2'b00) ? aw_err : {1'b0, awlock && resv_hit};
      end
      RD_MEM: begin
        state_d = RD_RESP;
        resv_v_d = (ok_q && lock_q) ? 1'b1 : resv_v_q;
        resv_idx_d = (ok_q && lock_q) ? addr_q : resv_idx_q;
      end
      RD_RESP: state_d = rready ? IDLE : RD_RESP;
      WR_MEM: begin
        state_d = WR_RESP;
        resv_v_d = (ok_q && resv_idx_q == addr_q) ? 1'b0 : resv_v_q;
      end
      WR_RESP: state_d = bready ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      resv_v_d = 1'b0;
      ok_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    addr_q <= addr_d;
    lock_q <= lock_d;
    ok_q <= ok_d;
    strb_q <= strb_d;
    data_q <= data_d;
    resp_q <= resp_d;
    resv_v_q <= resv_v_d;
    resv_idx_q <= resv_idx_d;
  end
  assign mem_en = !rst && ok_q && (state_q == RD_MEM || state_q == WR_MEM);
  assign mem_we = (!rst && ok_q && state_q == WR_MEM) ? strb_q : 4'b0000;
  assign mem_addr = addr_q;
  assign mem_wdata = data_q;
  assign rvalid = state_q == RD_RESP;
  assign rlast = rvalid;
  assign bvalid = state_q == WR_RESP;
  assign rdata = (rvalid && ok_q) ? AXI_DW'(mem_rdata) : '0;
  assign rresp = rvalid ? resp_q : 2'b00;
  assign bresp = bvalid ? resp_q : 2'b00;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized and directed checks of axi_mem_slave against a
// transaction-level model of memory contents, responses and the exclusive reservation.
module tb_axi_mem_slave;
  localparam int MB = 4096;
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata, mem_wdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 3'd2, arsize = 3'd2, awprot = 0, arprot = 0;
  logic [1:0] awburst = 1, arburst = 1, bresp, rresp;
  logic [3:0] awcache = 0, arcache = 0, wstrb = 0, mem_we;
  logic awlock = 0, arlock = 0, awvalid = 0, wvalid = 0, arvalid = 0, wlast = 1, bready = 0, rready = 0;
  logic awready, wready, bvalid, arready, rlast, rvalid, mem_en;
  logic [9:0] mem_addr;
  logic [31:0] mem_rdata = 0;
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
  logic ref_rv = 0;
  logic [9:0] ref_ri = 0;
  int en_cnt = 0, errs = 0, checks = 0;

  axi_mem_slave #(.MEM_BYTES(MB), .AXI_DW(32)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // environment memory: 1-cycle read latency, output held while idle
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      en_cnt <= en_cnt + 1;
      if (mem_we == 4'b0) mem_rdata <= mem[mem_addr];
      for (int i = 0; i < 4; i++) if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  function automatic logic [1:0] classify(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
    if (len != 0 || burst == 2'b00) return 2'b10;
    if (a >= MB) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst, input logic lk,
                            output logic [31:0] d, output logic [1:0] r, output int en);
    r = classify(a, len, burst); d = 0; en = 0;
    if (r == 2'b00) begin
      d = ref_mem[a[11:2]]; en = 1;
      if (lk) begin ref_rv = 1; ref_ri = a[11:2]; r = 2'b01; end
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst, input logic lk,
                             input logic [31:0] d, input logic [3:0] s, output logic [1:0] r, output int en);
    r = classify(a, len, burst); en = 0;
    if (r == 2'b00 && !(lk && !(ref_rv && ref_ri == a[11:2]))) begin
      en = 1; r = lk ? 2'b01 : 2'b00;
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
      if (ref_rv && ref_ri == a[11:2]) ref_rv = 0;
    end
  endtask

  task automatic axi_rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst, input logic lk, input int stall,
                        output logic [31:0] d, output logic [1:0] r, output int lat, output int en, output bit stable);
    int n, e0;
    e0 = en_cnt; lat = -1; d = 'x; r = 'x; stable = 1;
    araddr = a; arlen = len; arburst = burst; arlock = lk; arvalid = 1; #1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; arvalid = 0;
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n < 50) begin
      lat = n; d = rdata; r = rresp;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (rvalid !== 1'b1 || rdata !== d || rresp !== r || rlast !== 1'b1) stable = 0;
      end
      rready = 1; @(posedge clk); #1; rready = 0;
    end
    en = en_cnt - e0;
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst, input logic lk,
                        input logic [31:0] d, input logic [3:0] s, output logic [1:0] r, output int lat, output int en);
    int n, e0;
    e0 = en_cnt; lat = -1; r = 'x;
    awaddr = a; awlen = len; awburst = burst; awlock = lk; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; #1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n < 50) begin
      lat = n; r = bresp;
      bready = 1; @(posedge clk); #1; bready = 0;
    end
    en = en_cnt - e0;
  endtask

  task automatic test_reset;
    rst = 1; awvalid = 1; wvalid = 1; arvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
      errs++; $display("FAIL reset_ready ar=%b aw=%b w=%b expected 0 0 0", arready, awready, wready);
    end
    checks++;
    if (rvalid !== 0 || bvalid !== 0 || mem_en !== 0 || mem_we !== 0 || bresp !== 0 || rresp !== 0 || rdata !== 0) begin
      errs++; $display("FAIL reset_outs rv=%b bv=%b en=%b we=%h br=%b rr=%b rd=%h expected all 0", rvalid, bvalid, mem_en, mem_we, bresp, rresp, rdata);
    end
    awvalid = 0; wvalid = 0; rst = 0; ref_rv = 0; #1;
    checks++;
    if (arready !== 1'b1) begin errs++; $display("FAIL reset_release arready=%b expected 1", arready); end
  endtask

  task automatic test_basic;
    logic [31:0] d, ed; logic [1:0] r, er; int lat, en, ee; bit st;
    model_write(32'h10, 0, 1, 0, 32'hDEADBEEF, 4'hF, er, ee);
    axi_wr(32'h10, 0, 1, 0, 32'hDEADBEEF, 4'hF, r, lat, en);
    checks++;
    if (r !== er || lat !== 1 || en !== ee) begin errs++; $display("FAIL basic_wr bresp=%b lat=%0d en=%0d expected %b 1 %0d", r, lat, en, er, ee); end
    model_read(32'h10, 0, 1, 0, ed, er, ee);
    axi_rd(32'h10, 0, 1, 0, 0, d, r, lat, en, st);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 1 || en !== 1) begin
      errs++; $display("FAIL basic_rd rdata=%h rresp=%b lat=%0d en=%0d expected deadbeef 00 1 1", d, r, lat, en);
    end
    model_write(32'h14, 0, 2, 0, 32'h11223344, 4'b0101, er, ee);
    axi_wr(32'h14, 0, 2, 0, 32'h11223344, 4'b0101, r, lat, en);
    model_read(32'h14, 0, 1, 0, ed, er, ee);
    axi_rd(32'h14, 0, 1, 0, 0, d, r, lat, en, st);
    checks++;
    if (d !== ed || d !== 32'h00220044 || r !== er) begin errs++; $display("FAIL basic_strb rdata=%h rresp=%b expected %h %b", d, r, ed, er); end
  endtask

  task automatic test_exclusive;
    logic [31:0] d, ed; logic [1:0] r, er; int lat, en, ee; bit st;
    model_read(32'h20, 0, 1, 1, ed, er, ee);
    axi_rd(32'h20, 0, 1, 1, 0, d, r, lat, en, st);
    checks++;
    if (r !== 2'b01 || r !== er || d !== ed) begin errs++; $display("FAIL excl_lr rresp=%b rdata=%h expected 01 %h", r, d, ed); end
    model_write(32'h20, 0, 1, 1, 32'd5, 4'hF, er, ee);
    axi_wr(32'h20, 0, 1, 1, 32'd5, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b01 || en !== 1 || mem[8] !== 32'd5) begin errs++; $display("FAIL excl_lw1 bresp=%b en=%0d mem8=%h expected 01 1 5", r, en, mem[8]); end
    model_write(32'h20, 0, 1, 1, 32'd9, 4'hF, er, ee);
    axi_wr(32'h20, 0, 1, 1, 32'd9, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b00 || en !== 0 || mem[8] !== 32'd5) begin errs++; $display("FAIL excl_lw2 bresp=%b en=%0d mem8=%h expected 00 0 5", r, en, mem[8]); end
    model_read(32'h20, 0, 1, 1, ed, er, ee);
    axi_rd(32'h20, 0, 1, 1, 0, d, r, lat, en, st);
    model_write(32'h20, 0, 1, 0, 32'h77, 4'hF, er, ee);
    axi_wr(32'h20, 0, 1, 0, 32'h77, 4'hF, r, lat, en);
    model_write(32'h20, 0, 1, 1, 32'h88, 4'hF, er, ee);
    axi_wr(32'h20, 0, 1, 1, 32'h88, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b00 || en !== 0 || mem[8] !== 32'h77) begin errs++; $display("FAIL excl_cleared bresp=%b en=%0d mem8=%h expected 00 0 77", r, en, mem[8]); end
    model_read(32'h20, 0, 1, 1, ed, er, ee);
    axi_rd(32'h20, 0, 1, 1, 0, d, r, lat, en, st);
    model_write(32'h24, 0, 1, 0, 32'h99, 4'hF, er, ee);
    axi_wr(32'h24, 0, 1, 0, 32'h99, 4'hF, r, lat, en);
    model_write(32'h20, 0, 1, 1, 32'hAA, 4'hF, er, ee);
    axi_wr(32'h20, 0, 1, 1, 32'hAA, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b01 || en !== 1 || mem[8] !== 32'hAA) begin errs++; $display("FAIL excl_other bresp=%b en=%0d mem8=%h expected 01 1 aa", r, en, mem[8]); end
  endtask

  task automatic test_errors;
    logic [31:0] d, ed; logic [1:0] r, er; int lat, en, ee; bit st;
    model_read(32'h10, 3, 1, 0, ed, er, ee);
    axi_rd(32'h10, 3, 1, 0, 0, d, r, lat, en, st);
    checks++;
    if (r !== 2'b10 || d !== 0 || en !== 0 || lat !== 1) begin errs++; $display("FAIL err_len rresp=%b rdata=%h en=%0d lat=%0d expected 10 0 0 1", r, d, en, lat); end
    model_write(MB, 0, 1, 0, 32'h1234, 4'hF, er, ee);
    axi_wr(MB, 0, 1, 0, 32'h1234, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b11 || en !== 0) begin errs++; $display("FAIL err_dec_wr bresp=%b en=%0d expected 11 0", r, en); end
    model_read(32'h40, 0, 0, 1, ed, er, ee);
    axi_rd(32'h40, 0, 0, 1, 0, d, r, lat, en, st);
    checks++;
    if (r !== 2'b10 || en !== 0) begin errs++; $display("FAIL err_fixed_rd rresp=%b en=%0d expected 10 0", r, en); end
    model_read(32'hFFFF_FFF0, 0, 1, 1, ed, er, ee);
    axi_rd(32'hFFFF_FFF0, 0, 1, 1, 0, d, r, lat, en, st);
    checks++;
    if (r !== 2'b11 || d !== 0 || en !== 0) begin errs++; $display("FAIL err_dec_rd rresp=%b rdata=%h en=%0d expected 11 0 0", r, d, en); end
    model_write(32'h40, 0, 1, 1, 32'h55, 4'hF, er, ee);
    axi_wr(32'h40, 0, 1, 1, 32'h55, 4'hF, r, lat, en);
    checks++;
    if (r !== er || en !== ee || r !== 2'b00) begin errs++; $display("FAIL err_no_resv bresp=%b en=%0d expected 00 0", r, en); end
  endtask

  task automatic test_priority;
    logic [31:0] ed; logic [1:0] er; int ee, e0, n; bit aw_seen;
    e0 = en_cnt;
    model_read(32'h30, 0, 1, 0, ed, er, ee);
    araddr = 32'h30; arlen = 0; arburst = 1; arlock = 0;
    awaddr = 32'h34; awlen = 0; awburst = 1; awlock = 0; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    arvalid = 1; awvalid = 1; wvalid = 1; #1;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
      errs++; $display("FAIL prio_first ar=%b aw=%b w=%b expected 1 0 0", arready, awready, wready);
    end
    @(posedge clk); #1; arvalid = 0;
    aw_seen = 0; n = 0;
    while (rvalid !== 1'b1 && n < 50) begin if (awready !== 1'b0) aw_seen = 1; @(posedge clk); #1; n++; end
    checks++;
    if (rdata !== ed || rresp !== er || n !== 1) begin errs++; $display("FAIL prio_rd rdata=%h rresp=%b lat=%0d expected %h %b 1", rdata, rresp, n, ed, er); end
    rready = 1; @(posedge clk); #1; rready = 0;
    checks++;
    if (aw_seen || awready !== 1'b1) begin errs++; $display("FAIL prio_aw seen_during_read=%0d awready_after=%b expected 0 1", aw_seen, awready); end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    model_write(32'h34, 0, 1, 0, 32'hCAFEF00D, 4'hF, er, ee);
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (bresp !== er || n !== 1) begin errs++; $display("FAIL prio_wr bresp=%b lat=%0d expected %b 1", bresp, n, er); end
    bready = 1; @(posedge clk); #1; bready = 0;
    checks++;
    if (en_cnt - e0 !== 2 || mem[13] !== 32'hCAFEF00D) begin errs++; $display("FAIL prio_mem en=%0d mem13=%h expected 2 cafef00d", en_cnt - e0, mem[13]); end
  endtask

  task automatic test_stall_and_reset;
    logic [31:0] d, ed; logic [1:0] r, er; int lat, en, ee, n; bit st;
    model_read(32'h10, 0, 1, 1, ed, er, ee);
    axi_rd(32'h10, 0, 1, 1, 5, d, r, lat, en, st);
    checks++;
    if (!st || d !== ed || r !== er || r !== 2'b01) begin errs++; $display("FAIL stall_rd stable=%0d rdata=%h rresp=%b expected 1 %h %b", st, d, r, ed, er); end
    model_write(32'h80, 0, 1, 0, 32'h0BADF00D, 4'hF, er, ee);
    awaddr = 32'h80; awlen = 0; awburst = 1; awlock = 0; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; #1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1; ref_rv = 0;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0 || bresp !== 2'b00) begin errs++; $display("FAIL rst_wresp bvalid=%b bresp=%b expected 0 00", bvalid, bresp); end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bvalid !== 1'b0 || mem[32] !== 32'h0BADF00D) begin errs++; $display("FAIL rst_abandon bvalid=%b mem32=%h expected 0 0badf00d", bvalid, mem[32]); end
    model_write(32'h10, 0, 1, 1, 32'h4321, 4'hF, er, ee);
    axi_wr(32'h10, 0, 1, 1, 32'h4321, 4'hF, r, lat, en);
    checks++;
    if (r !== 2'b00 || en !== 0 || r !== er) begin errs++; $display("FAIL rst_resv bresp=%b en=%0d expected 00 0", r, en); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, ed, wd; logic [1:0] r, er, bu; logic [7:0] len; logic [3:0] s; logic lk;
    int lat, en, ee, k; bit st;
    for (int t = 0; t < 60; t++) begin
      a = 32'($urandom_range(0, 7)) << 2 | 32'($urandom_range(0, 3));
      len = 0; bu = 2'($urandom_range(1, 2)); lk = 1'($urandom_range(0, 1));
      wd = $urandom; s = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 11);
      if (k == 0) a = a + MB;
      if (k == 1) len = 8'($urandom_range(1, 255));
      if (k == 2) bu = 2'b00;
      if ($urandom_range(0, 1) == 0) begin
        model_read(a, len, bu, lk, ed, er, ee);
        axi_rd(a, len, bu, lk, $urandom_range(0, 2), d, r, lat, en, st);
        checks++;
        if (d !== ed || r !== er || en !== ee || lat !== 1 || !st) begin
          errs++; $display("FAIL rand_rd a=%h lk=%b rdata=%h rresp=%b en=%0d lat=%0d st=%0d expected %h %b %0d 1 1", a, lk, d, r, en, lat, st, ed, er, ee);
        end
      end else begin
        model_write(a, len, bu, lk, wd, s, er, ee);
        axi_wr(a, len, bu, lk, wd, s, r, lat, en);
        checks++;
        if (r !== er || en !== ee || lat !== 1) begin
          errs++; $display("FAIL rand_wr a=%h lk=%b bresp=%b en=%0d lat=%0d expected %b %0d 1", a, lk, r, en, lat, er, ee);
        end
      end
    end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin errs++; $display("FAIL rand_mem word=%0d got=%h expected %h", w, mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_exclusive;
    test_errors;
    test_priority;
    test_stall_and_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
